truth_table_sequencer: RTL and testbench
========================================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning the number of extra wait cycles after applying each vector before sampling (legal range 0..15).
REQ-002 SHALL have port clk  input  1  system clock, rising edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to run one full 16-vector sweep.
REQ-005 SHALL have port abort  input  1  cancel a running sweep.
REQ-006 SHALL have port exp_x  input  16  expected x truth table, bit i = expected x for vector i.
REQ-007 SHALL have port exp_y  input  16  expected y truth table, bit i = expected y for vector i.
REQ-008 SHALL have port x_in  input  1  x output of the combinational block under control.
REQ-009 SHALL have port y_in  input  1  y output of the combinational block under control.
REQ-010 SHALL have ports a, b, c, d  output  1 each  drive of the block inputs: a=idx[3], b=idx[2], c=idx[1], d=idx[0].
REQ-011 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-012 SHALL have port done  output  1  single-cycle pulse at sweep completion.
REQ-013 SHALL have ports table_x, table_y  output  16 each  captured x/y per vector index.
REQ-014 SHALL have port mismatch_cnt  output  5  count of vectors with x or y differing from expected (0..16).
REQ-015 SHALL have ports first_fail  output  4 and fail_seen  output  1  index of the first mismatching vector and its valid flag.
REQ-016 SHALL have port pass  output  1  high after a completed sweep with mismatch_cnt==0.

Function
REQ-017 SHALL implement states IDLE, WAIT, SAMPLE, DONE.
REQ-018 IDLE: start=1 at a rising edge SHALL move to WAIT, clear idx, table_x, table_y, mismatch_cnt, fail_seen, first_fail and pass, latch exp_x/exp_y, and load the settle counter with SETTLE.
REQ-019 WAIT: counter==0 SHALL move to SAMPLE; otherwise the counter SHALL decrement; WAIT therefore lasts SETTLE+1 cycles.
REQ-020 SAMPLE SHALL write x_in to table_x[idx] and y_in to table_y[idx], and compare both against the latched expected bits at idx.
REQ-021 On a mismatch, SAMPLE SHALL increment mismatch_cnt; if fail_seen==0, it SHALL also set fail_seen and load first_fail=idx.
REQ-022 SAMPLE with idx!=15 SHALL increment idx, reload the counter and return to WAIT; with idx==15 it SHALL move to DONE without wrapping idx.
REQ-023 DONE SHALL assert done for exactly one cycle, set pass=(mismatch_cnt==0) and return to IDLE.
REQ-024 Per-vector period SHALL be SETTLE+2 cycles; done SHALL be high in the cycle starting 16*(SETTLE+2) edges after the start-accept edge.
REQ-025 busy SHALL be high exactly in WAIT and SAMPLE.
REQ-026 a..d SHALL reflect idx throughout a sweep and SHALL return to 0 in IDLE and DONE.
REQ-027 start while busy or in DONE SHALL be ignored.
REQ-028 abort in WAIT or SAMPLE SHALL force IDLE at the next edge with priority over sampling; the abort-cycle sample SHALL NOT be written, results already captured SHALL be kept, and done and pass SHALL stay 0.
REQ-029 abort in IDLE or DONE SHALL have no effect; simultaneous start and abort in IDLE SHALL start the sweep.
REQ-030 pass, tables and fail info SHALL hold until the next accepted start.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, idx=0, counter=0, a..d=0, busy=0, done=0, table_x=table_y=0, mismatch_cnt=0, first_fail=0, fail_seen=0, pass=0.
REQ-032 Reset asserted mid-sweep SHALL discard the sweep with no done pulse; the first start after rst_n rises SHALL run a full sweep from idx 0.

Verification
REQ-033 Model x=a^b, y=c|d, exp_x=16'h0FF0, exp_y=16'hEEEE, SETTLE=1, pulse start -> done exactly 48 cycles later, table_x=16'h0FF0, table_y=16'hEEEE, mismatch_cnt=0, pass=1, fail_seen=0.
REQ-034 Same model with exp_x=16'h0FF1, exp_y=16'hEEEA -> mismatch_cnt=2, first_fail=0, fail_seen=1, pass=0.
REQ-035 SETTLE=0, same model -> done 32 cycles after start accept; a..d observed stepping 0000..1111 in order, each held 2 cycles.
REQ-036 Abort asserted while idx=5 is in WAIT -> IDLE next edge, busy=0, no done, table_x[4:0] kept, table_x[15:5]=0, pass=0.
REQ-037 start re-pulsed at cycle 10 of a sweep -> ignored, done still at cycle 48; rst_n low at cycle 20 -> all outputs 0 immediately, no done pulse.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// Sweeps all 16 input vectors of a 4-input/2-output combinational block,
// captures its x/y responses and scores them against expected truth tables.
module truth_table_sequencer #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] exp_x,
    input  logic [15:0] exp_y,
    input  logic        x_in,
    input  logic        y_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_x,
    output logic [15:0] table_y,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail,
    output logic        fail_seen,
    output logic        pass
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  cnt_q;
    logic [3:0]  drv_q;
    logic [15:0] exp_x_q;
    logic [15:0] exp_y_q;
    logic [15:0] tx_q;
    logic [15:0] ty_q;
    logic [4:0]  mcnt_q;
    logic [3:0]  ff_q;
    logic        fs_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic        sample_bad;

    assign sample_bad = (x_in != exp_x_q[idx_q]) || (y_in != exp_y_q[idx_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            drv_q   <= '0;
            exp_x_q <= '0;
            exp_y_q <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            mcnt_q  <= '0;
            ff_q    <= '0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking default then override; the last assignment in the block wins.
            done_q <= 1'b0;
            if (abort && (state_q == S_WAIT || state_q == S_SAMPLE)) begin
                // Abort beats sampling: this cycle's x/y is dropped, prior captures stay.
                state_q <= S_IDLE;
                idx_q   <= '0;
                cnt_q   <= '0;
                drv_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q <= S_WAIT;
                            idx_q   <= '0;
                            cnt_q   <= SETTLE_C;
                            drv_q   <= '0;
                            exp_x_q <= exp_x;
                            exp_y_q <= exp_y;
                            tx_q    <= '0;
                            ty_q    <= '0;
                            mcnt_q  <= '0;
                            ff_q    <= '0;
                            fs_q    <= 1'b0;
                            pass_q  <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (cnt_q == 4'd0) state_q <= S_SAMPLE;
                        else               cnt_q   <= cnt_q - 4'd1;
                    end
                    S_SAMPLE: begin
                        tx_q[idx_q] <= x_in;
                        ty_q[idx_q] <= y_in;
                        if (sample_bad) begin
                            mcnt_q <= mcnt_q + 5'd1;
                            if (!fs_q) begin
                                fs_q <= 1'b1;
                                ff_q <= idx_q;
                            end
                        end
                        if (idx_q != 4'd15) begin
                            idx_q   <= idx_q + 4'd1;
                            drv_q   <= idx_q + 4'd1;
                            cnt_q   <= SETTLE_C;
                            state_q <= S_WAIT;
                        end else begin
                            // Pass uses the final vector's result, which is not yet in mcnt_q.
                            state_q <= S_DONE;
                            drv_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (mcnt_q == 5'd0) && !sample_bad;
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign {a, b, c, d}  = drv_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign table_x       = tx_q;
    assign table_y       = ty_q;
    assign mismatch_cnt  = mcnt_q;
    assign first_fail    = ff_q;
    assign fail_seen     = fs_q;
    assign pass          = pass_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: two instances (SETTLE=1 and SETTLE=0) each drive
// an x=a^b, y=c|d block; a reference model fills a scoreboard checked at sweep end.
module tb_truth_table_sequencer;

    localparam int NONE = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, abort1 = 1'b0, start0 = 1'b0, abort0 = 1'b0;
    logic [15:0] exp_x = '0, exp_y = '0;

    logic a1, b1, c1, d1, busy1, done1, fs1, pass1;
    logic a0, b0, c0, d0, busy0, done0, fs0, pass0;
    logic [15:0] tx1, ty1, tx0, ty0;
    logic [4:0]  cnt1, cnt0;
    logic [3:0]  ff1, ff0;
    logic        x1, y1, x0, y0;

    assign x1 = a1 ^ b1;
    assign y1 = c1 | d1;
    assign x0 = a0 ^ b0;
    assign y0 = c0 | d0;

    truth_table_sequencer #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .exp_x(exp_x), .exp_y(exp_y), .x_in(x1), .y_in(y1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .table_x(tx1), .table_y(ty1), .mismatch_cnt(cnt1),
        .first_fail(ff1), .fail_seen(fs1), .pass(pass1)
    );

    truth_table_sequencer #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .exp_x(exp_x), .exp_y(exp_y), .x_in(x0), .y_in(y0),
        .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
        .table_x(tx0), .table_y(ty0), .mismatch_cnt(cnt0),
        .first_fail(ff0), .fail_seen(fs0), .pass(pass0)
    );

    always #5 clk = ~clk;

    // Observation mux: sel=1 watches dut1, sel=0 watches dut0.
    bit sel = 1'b1;
    logic [3:0]  abcd_s;
    logic [15:0] tx_s, ty_s;
    logic [4:0]  cnt_s;
    logic [3:0]  ff_s;
    logic        busy_s, done_s, fs_s, pass_s;
    int          settle_s;
    assign abcd_s   = sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0};
    assign busy_s   = sel ? busy1 : busy0;
    assign done_s   = sel ? done1 : done0;
    assign tx_s     = sel ? tx1 : tx0;
    assign ty_s     = sel ? ty1 : ty0;
    assign cnt_s    = sel ? cnt1 : cnt0;
    assign ff_s     = sel ? ff1 : ff0;
    assign fs_s     = sel ? fs1 : fs0;
    assign pass_s   = sel ? pass1 : pass0;
    assign settle_s = sel ? 1 : 0;

    typedef struct {
        logic [15:0] tx;
        logic [15:0] ty;
        logic [4:0]  cnt;
        logic [3:0]  ff;
        logic        fs;
        logic        pass;
        logic        done;
        int          lat;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] trace [0:127];
    int         n_assert = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: sweep the first nvec vectors of x=a^b, y=c|d against ex/ey.
    function automatic exp_t model(input logic [15:0] ex, input logic [15:0] ey,
                                   input int settle, input int nvec, input bit full);
        exp_t e;
        e.tx = '0; e.ty = '0; e.cnt = '0; e.ff = '0; e.fs = 1'b0;
        for (int i = 0; i < nvec; i++) begin
            logic [3:0] v;
            logic xv, yv;
            v = 4'(i);
            xv = v[3] ^ v[2];
            yv = v[1] | v[0];
            e.tx[i] = xv;
            e.ty[i] = yv;
            if (xv != ex[i] || yv != ey[i]) begin
                if (!e.fs) begin
                    e.fs = 1'b1;
                    e.ff = v;
                end
                e.cnt = e.cnt + 5'd1;
            end
        end
        e.done = full;
        e.pass = full && (e.cnt == 5'd0);
        e.lat  = 16 * (settle + 2);
        return e;
    endfunction

    task automatic set_start(input logic v);
        if (sel) start1 = v; else start0 = v;
    endtask

    task automatic set_abort(input logic v);
        if (sel) abort1 = v; else abort0 = v;
    endtask

    // lat counts edges after the start-accept edge; sampling happens on negedges.
    task automatic sweep(input bit abort_ws, input int restart_at, input int abort_at,
                         input int rst_at, input int budget, output int lat, output bit saw);
        lat = 0;
        saw = 1'b0;
        @(negedge clk);
        set_start(1'b1);
        set_abort(abort_ws);
        @(posedge clk);
        while (lat <= budget) begin
            @(negedge clk);
            set_start(lat == restart_at);
            set_abort(lat == abort_at);
            if (lat == 0) check("busy_after_accept", busy_s, 1);
            if (lat == abort_at) check("abort_point_idx", abcd_s, abort_at / (settle_s + 2));
            if (lat == abort_at + 1) begin
                check("abort_busy", busy_s, 0);
                check("abort_abcd", abcd_s, 0);
            end
            if (lat == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", busy_s, 0);
                check("rst_abcd", abcd_s, 0);
                check("rst_tx", tx_s, 0);
                check("rst_cnt", cnt_s, 0);
                check("rst_fs", fs_s, 0);
            end
            if (lat == rst_at + 3) rst_n = 1'b1;
            if (done_s) begin
                saw = 1'b1;
                break;
            end
            if (lat < 128) trace[lat] = abcd_s;
            lat++;
            @(posedge clk);
        end
    endtask

    task automatic score(input int lat, input bit saw);
        exp_t e;
        e = sb_q.pop_front();
        check("done_seen", saw, e.done);
        if (e.done) check("done_latency", lat, e.lat);
        check("table_x", tx_s, e.tx);
        check("table_y", ty_s, e.ty);
        check("mismatch_cnt", cnt_s, e.cnt);
        check("first_fail", ff_s, e.ff);
        check("fail_seen", fs_s, e.fs);
        check("pass", pass_s, e.pass);
    endtask

    task automatic after_done();
        logic p;
        p = pass_s;
        @(negedge clk);
        check("done_one_cycle", done_s, 0);
        check("idle_busy", busy_s, 0);
        check("idle_abcd", abcd_s, 0);
        check("pass_hold", pass_s, p);
    endtask

    initial begin
        int  lat;
        bit  saw;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_busy", busy_s, 0);
        check("reset_done", done_s, 0);
        check("reset_abcd", abcd_s, 0);
        check("reset_tables", {tx_s, ty_s}, 0);
        check("reset_cnt", cnt_s, 0);
        check("reset_fail", {ff_s, fs_s, pass_s}, 0);
        check("reset_dut0_busy", busy0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean sweep, SETTLE=1
        sel = 1'b1;
        exp_x = 16'h0FF0; exp_y = 16'hEEEE;
        sb_q.push_back(model(exp_x, exp_y, 1, 16, 1'b1));
        sweep(1'b0, NONE, NONE, NONE, 100, lat, saw);
        score(lat, saw);
        after_done();

        // Two mismatches; start and abort together in IDLE must start
        exp_x = 16'h0FF1; exp_y = 16'hEEEA;
        sb_q.push_back(model(exp_x, exp_y, 1, 16, 1'b1));
        sweep(1'b1, NONE, NONE, NONE, 100, lat, saw);
        score(lat, saw);
        after_done();

        // Abort while idle is ignored and results hold
        abort1 = 1'b1;
        repeat (3) @(negedge clk);
        abort1 = 1'b0;
        check("idle_abort_busy", busy_s, 0);
        check("idle_abort_tx", tx_s, 16'h0FF0);
        check("idle_abort_cnt", cnt_s, 2);

        // SETTLE=0 sweep with a..d stepping trace
        sel = 1'b0;
        exp_x = 16'h0FF0; exp_y = 16'hEEEE;
        sb_q.push_back(model(exp_x, exp_y, 0, 16, 1'b1));
        sweep(1'b0, NONE, NONE, NONE, 100, lat, saw);
        score(lat, saw);
        for (int k = 0; k < 32; k++)
            check($sformatf("abcd_step_%0d", k), trace[k], k / 2);
        after_done();

        // Re-start during a sweep is ignored
        sel = 1'b1;
        sb_q.push_back(model(exp_x, exp_y, 1, 16, 1'b1));
        sweep(1'b0, 10, NONE, NONE, 100, lat, saw);
        score(lat, saw);
        after_done();

        // Abort with idx=5 in WAIT: keep vectors 0..4, no done
        sb_q.push_back(model(exp_x, exp_y, 1, 5, 1'b0));
        sweep(1'b0, NONE, 15, NONE, 60, lat, saw);
        score(lat, saw);

        // Reset mid-sweep: everything cleared, no done
        sb_q.push_back(model(exp_x, exp_y, 1, 0, 1'b0));
        sweep(1'b0, NONE, NONE, 20, 60, lat, saw);
        score(lat, saw);

        // First sweep after reset runs fully from idx 0
        sb_q.push_back(model(exp_x, exp_y, 1, 16, 1'b1));
        sweep(1'b0, NONE, NONE, NONE, 100, lat, saw);
        score(lat, saw);
        after_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
